button_debouncer: RTL

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

---
 rtl/button_debouncer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/button_debouncer.sv
// Push-button debouncer: synchronizes a raw input, qualifies each new level
// for DEBOUNCE_CYCLES cycles and reports level plus edge pulses.
//
// Ports:
//   clk        - system clock, all state on rising edge
//   rst_n      - asynchronous active-low reset
//   in         - raw asynchronous button/switch level
//   level      - debounced registered level
//   rise_pulse - one-cycle pulse when level goes 0->1
//   fall_pulse - one-cycle pulse when level goes 1->0
//   busy       - high while a candidate transition is being qualified

module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic level,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        STABLE_LOW,
        PEND_HIGH,
        STABLE_HIGH,
        PEND_LOW
    } state_t;

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync;
    state_t                 state;
    logic [CNT_W-1:0]       cnt;

    // Only the last stage is used; earlier stages may be metastable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], in};
        end
    end

    assign sync = sync_ff[SYNC_STAGES-1];

    // cnt holds the number of consecutive qualifying samples seen so far;
    // acceptance happens on the sample that would make it DEBOUNCE_CYCLES,
    // so it never exceeds DEBOUNCE_CYCLES-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= STABLE_LOW;
            cnt        <= '0;
            level      <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            unique case (state)
                STABLE_LOW: begin
                    if (sync) begin
                        state <= PEND_HIGH;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end else begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end
                end
                PEND_HIGH: begin
                    if (!sync) begin
                        state <= STABLE_LOW;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state      <= STABLE_HIGH;
                        cnt        <= '0;
                        level      <= 1'b1;
                        rise_pulse <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                STABLE_HIGH: begin
                    if (!sync) begin
                        state <= PEND_LOW;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end else begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end
                end
                PEND_LOW: begin
                    if (sync) begin
                        state <= STABLE_HIGH;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state      <= STABLE_LOW;
                        cnt        <= '0;
                        level      <= 1'b0;
                        fall_pulse <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
            endcase
        end
    end

endmodule
